// File: rtl/serial_sub8.sv
// Bit-serial subtractor D = A - B - Bin, one bit per clock, LSB first, start/done handshake.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output OVF.
module serial_sub8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             OVF
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, b_sr_q;
    logic [WIDTH-2:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic [CW-1:0]    cnt_q;
    logic             br_q, br_d;
    logic [WIDTH-1:0] d_q;
    logic             bout_q;
    logic             d_bit;
    logic             accept;
    logic             last;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb_q, b_msb_q, ovf_q;
`endif

    assign d_bit = a_sr_q[0] ^ b_sr_q[0] ^ br_q;
    assign br_d  = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & br_q);
    // Full result word as it will look after this bit is shifted in.
    assign res_d = {d_bit, res_q};

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == LAST_CNT) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr_q <= '0;
            b_sr_q <= '0;
            res_q  <= '0;
            cnt_q  <= '0;
            br_q   <= 1'b0;
            d_q    <= '0;
            bout_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else if (accept) begin
            a_sr_q <= A;
            b_sr_q <= B;
            br_q   <= Bin;
            cnt_q  <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= A[WIDTH-1];
            b_msb_q <= B[WIDTH-1];
`endif
        end else if (state_q == RUN) begin
            a_sr_q <= a_sr_q >> 1;
            b_sr_q <= b_sr_q >> 1;
            br_q   <= br_d;
            res_q  <= res_d[WIDTH-1:1];
            cnt_q  <= cnt_q + CW'(1);
            // Visible outputs only move on the final bit.
            if (last) begin
                d_q    <= res_d;
                bout_q <= br_d;
`ifdef SERIAL_SUB_OVF_EN
                ovf_q  <= (a_msb_q ^ b_msb_q) & (a_msb_q ^ d_bit);
`endif
            end
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign D    = d_q;
    assign Bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign OVF  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub8.sv
// Directed self-checking bench for serial_sub8 (WIDTH=8); OVF checks when SERIAL_SUB_OVF_EN is defined.
module tb_serial_sub8;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [7:0] d;
    logic       bout;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_sub8 #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (a),
        .B     (b),
        .Bin   (bin),
        .busy  (busy),
        .done  (done),
        .D     (d),
        .Bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .OVF   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Starts one operation, waits (bounded) for done and checks the result.
    task automatic run_op(input string tag, input logic [7:0] a_v, input logic [7:0] b_v,
                          input logic bin_v, input logic [7:0] exp_d, input logic exp_b);
        logic [7:0] d_prev;
        int n;
        int nb;
        d_prev = d;
        a = a_v;
        b = b_v;
        bin = bin_v;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        bin = 1'($urandom);
        n = 0;
        nb = 0;
        while (done !== 1'b1 && n < 20) begin
            if (busy === 1'b1) nb++;
            if (n == 4) check({tag, "_hold"}, {24'd0, d}, {24'd0, d_prev});
            tick();
            n++;
        end
        check({tag, "_lat"}, n, 8);
        check({tag, "_busycyc"}, nb, 8);
        check({tag, "_busy0"}, {31'd0, busy}, 0);
        check({tag, "_res"}, {23'd0, bout, d}, {23'd0, exp_b, exp_d});
`ifdef SERIAL_SUB_OVF_EN
        check({tag, "_ovf"}, {31'd0, ovf},
              {31'd0, (a_v[7] ^ b_v[7]) & (a_v[7] ^ exp_d[7])});
`endif
        tick();
        check({tag, "_pulse"}, {31'd0, done}, 0);
    endtask

    initial begin
        logic [8:0] model;
        logic       saw_done;

        rst_n = 1'b0;
        start = 1'b0;
        a = 8'd0;
        b = 8'd0;
        bin = 1'b0;
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_out", {23'd0, bout, d}, 0);
        rst_n = 1'b1;
        tick();

        // Reset in the middle of a run aborts silently.
        a = 8'd93;
        b = 8'd43;
        bin = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("mid_busy", {31'd0, busy}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 0);
        check("arst_done", {31'd0, done}, 0);
        check("arst_out", {23'd0, bout, d}, 0);
        #3;
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) saw_done = 1'b1;
        end
        check("arst_nodone", {31'd0, saw_done}, 0);

        run_op("basic", 8'd93, 8'd43, 1'b1, 8'd49, 1'b0);
        run_op("under", 8'd0, 8'd12, 1'b1, 8'd243, 1'b1);
        run_op("sovf", 8'd128, 8'd32, 1'b1, 8'd95, 1'b0);
        run_op("zero", 8'd0, 8'd0, 1'b0, 8'd0, 1'b0);
        run_op("allbr", 8'd0, 8'd255, 1'b1, 8'd0, 1'b1);
        run_op("max", 8'd255, 8'd0, 1'b0, 8'd255, 1'b0);

        // Back-to-back with an ignored mid-run start.
        a = 8'd32;
        b = 8'd34;
        bin = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        a = 8'd1;
        b = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("b2b_done1", {31'd0, done}, 1);
        check("b2b_res1", {23'd0, bout, d}, {23'd0, 1'b1, 8'd254});
        a = 8'd5;
        b = 8'd3;
        bin = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_pulse", {31'd0, done}, 0);
        check("b2b_busy", {31'd0, busy}, 1);
        for (int i = 0; i < 4; i++) tick();
        check("b2b_hold", {23'd0, bout, d}, {23'd0, 1'b1, 8'd254});
        for (int i = 0; i < 3; i++) tick();
        check("b2b_early", {31'd0, done}, 0);
        tick();
        check("b2b_done2", {31'd0, done}, 1);
        check("b2b_res2", {23'd0, bout, d}, {23'd0, 1'b0, 8'd2});
        tick();
        check("b2b_idle", {31'd0, done | busy}, 0);

        // Strided sweep including 0 and 255 for both operands.
        for (int ia = 0; ia <= 255; ia += 17) begin
            for (int ib = 0; ib <= 255; ib += 15) begin
                for (int ic = 0; ic < 2; ic++) begin
                    model = {1'b0, 8'(ia)} - {1'b0, 8'(ib)} - 9'(ic);
                    run_op("sweep", 8'(ia), 8'(ib), 1'(ic), model[7:0], model[8]);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
